// File: rtl/phy_tx_defs.sv
// Shared definitions for the PHY TX lane arbiter: link symbols, lane count,
// lane index type and the training/active FSM encoding.
package phy_tx_defs;

    localparam int         NLANES  = 4;
    localparam int         DATA_W  = 8;
    localparam logic [7:0] COM_SYM = 8'hBC;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return idx + lane_idx_t'(1);
    endfunction

endpackage

// File: rtl/phy_tx_lane_fifo.sv
// Per-lane byte FIFO. A push into a full FIFO is ignored even when the same
// cycle pops, so callers can flag the drop from the registered full flag alone.
module phy_tx_lane_fifo
    import phy_tx_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/phy_tx_lane_arbiter.sv
// Round-robin scheduler sharing the PHY TX byte path among four buffered lanes,
// holding traffic while the link reports it is still training.
module phy_tx_lane_arbiter
    import phy_tx_defs::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] IDLE_SYM = COM_SYM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] In0,
    input  logic [7:0] In1,
    input  logic [7:0] In2,
    input  logic [7:0] In3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    input  logic       recirculacion,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant_lane,
    output logic       full0,
    output logic       full1,
    output logic       full2,
    output logic       full3,
    output logic [3:0] ovf
);

    logic [DATA_W-1:0] lane_din  [NLANES];
    logic [DATA_W-1:0] lane_dout [NLANES];
    logic [NLANES-1:0] lane_vld;
    logic [NLANES-1:0] lane_pop;
    logic [NLANES-1:0] lane_full;
    logic [NLANES-1:0] lane_empty;

    state_t            state;
    lane_idx_t         rr_ptr;
    logic              pick_any_p0;
    lane_idx_t         pick_idx_p0;
    logic              pop_en_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    lane_idx_t         grant_p1;

    assign lane_din[0] = In0;
    assign lane_din[1] = In1;
    assign lane_din[2] = In2;
    assign lane_din[3] = In3;
    assign lane_vld    = {valid3, valid2, valid1, valid0};

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        phy_tx_lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (lane_vld[g]),
            .pop   (lane_pop[g]),
            .din   (lane_din[g]),
            .dout  (lane_dout[g]),
            .full  (lane_full[g]),
            .empty (lane_empty[g])
        );
    end

    // Stage p0: pick the first non-empty lane starting at the rr pointer.
    always_comb begin
        pick_any_p0 = 1'b0;
        pick_idx_p0 = rr_ptr;
        for (int i = 0; i < NLANES; i++) begin
            if (!pick_any_p0 && !lane_empty[rr_ptr + lane_idx_t'(i)]) begin
                pick_any_p0 = 1'b1;
                pick_idx_p0 = rr_ptr + lane_idx_t'(i);
            end
        end
    end

    assign pop_en_p0 = (state == ACTIVE) && !recirculacion && pick_any_p0;

    always_comb begin
        lane_pop = '0;
        for (int l = 0; l < NLANES; l++) begin
            lane_pop[l] = pop_en_p0 && (pick_idx_p0 == lane_idx_t'(l));
        end
    end

    // Stage p1: FSM, rr pointer and the registered output byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TRAIN;
            rr_ptr   <= '0;
            data_p1  <= IDLE_SYM;
            vld_p1   <= 1'b0;
            grant_p1 <= '0;
        end else begin
            data_p1 <= IDLE_SYM;
            vld_p1  <= 1'b0;
            case (state)
                TRAIN: begin
                    if (!recirculacion) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (recirculacion) begin
                        state <= TRAIN;
                    end else if (pop_en_p0) begin
                        data_p1  <= lane_dout[pick_idx_p0];
                        vld_p1   <= 1'b1;
                        grant_p1 <= pick_idx_p0;
                        rr_ptr   <= next_lane(pick_idx_p0);
                    end
                end
                default: state <= TRAIN;
            endcase
        end
    end

    // Overflow is sticky: a byte offered while its lane is full is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (lane_vld & lane_full);
        end
    end

    assign data_out   = data_p1;
    assign valid_out  = vld_p1;
    assign grant_lane = grant_p1;
    assign full0      = lane_full[0];
    assign full1      = lane_full[1];
    assign full2      = lane_full[2];
    assign full3      = lane_full[3];

endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// Bench for phy_tx_lane_arbiter: per-cycle vector table plus a per-lane
// scoreboard that checks every emitted byte against the bytes offered.
module tb_phy_tx_lane_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] In0, In1, In2, In3;
    logic       valid0, valid1, valid2, valid3;
    logic       recirculacion;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] grant_lane;
    logic       full0, full1, full2, full3;
    logic [3:0] ovf;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbq [4][$];

    typedef struct packed {
        logic        rst;
        logic        rc;
        logic [3:0]  vld;
        logic [3:0]  drop;
        logic [31:0] din;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  eg;
        logic [3:0]  ef;
        logic [3:0]  eo;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];

    phy_tx_lane_arbiter #(.DEPTH(4), .IDLE_SYM(8'hBC)) dut (
        .clk           (clk),
        .reset         (reset),
        .In0           (In0),
        .In1           (In1),
        .In2           (In2),
        .In3           (In3),
        .valid0        (valid0),
        .valid1        (valid1),
        .valid2        (valid2),
        .valid3        (valid3),
        .recirculacion (recirculacion),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .grant_lane    (grant_lane),
        .full0         (full0),
        .full1         (full1),
        .full2         (full2),
        .full3         (full3),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic rst, input logic rc, input logic [3:0] vld,
                               input logic [3:0] drop, input logic [31:0] din,
                               input logic ev, input logic [7:0] ed, input logic [1:0] eg,
                               input logic [3:0] ef, input logic [3:0] eo);
        vec_t r;
        r.rst = rst; r.rc = rc; r.vld = vld; r.drop = drop; r.din = din;
        r.ev = ev; r.ed = ed; r.eg = eg; r.ef = ef; r.eo = eo;
        return r;
    endfunction

    task automatic flush_sb();
        for (int l = 0; l < 4; l++) sbq[l].delete();
    endtask

    task automatic drive(input logic [3:0] vld, input logic [31:0] din, input logic [3:0] drop);
        {valid3, valid2, valid1, valid0} = vld;
        {In3, In2, In1, In0} = din;
        for (int l = 0; l < 4; l++)
            if (vld[l] && !drop[l]) sbq[l].push_back(din[8*l +: 8]);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid byte must be the oldest pending byte of its lane.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sbq[grant_lane].size() == 0) begin
                chk("sb_stale_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_lane_data", {24'h0, data_out}, {24'h0, sbq[grant_lane].pop_front()});
            end
        end else begin
            chk("idle_symbol", {24'h0, data_out}, 32'h0000_00BC);
        end
    end

    initial begin
        // rst rc vld drop din ev ed eg ef eo
        tbl[0]  = v(0,1,4'b0001,4'b0000,32'h0000_0011, 0,8'hBC,2'd0,4'b0000,4'b0000);
        tbl[1]  = v(0,1,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd0,4'b0000,4'b0000);
        tbl[2]  = v(1,1,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd0,4'b0000,4'b0000);
        tbl[3]  = v(0,1,4'b1111,4'b0000,32'hA3A2_A1A0,  0,8'hBC,2'd0,4'b0000,4'b0000);
        tbl[4]  = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd0,4'b0000,4'b0000);
        tbl[5]  = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hA0,2'd0,4'b0000,4'b0000);
        tbl[6]  = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hA1,2'd1,4'b0000,4'b0000);
        tbl[7]  = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hA2,2'd2,4'b0000,4'b0000);
        tbl[8]  = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hA3,2'd3,4'b0000,4'b0000);
        tbl[9]  = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0000,4'b0000);
        tbl[10] = v(0,1,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0000,4'b0000);
        tbl[11] = v(0,1,4'b0010,4'b0000,32'h0000_B000,  0,8'hBC,2'd3,4'b0000,4'b0000);
        tbl[12] = v(0,1,4'b0010,4'b0000,32'h0000_B100,  0,8'hBC,2'd3,4'b0000,4'b0000);
        tbl[13] = v(0,1,4'b0010,4'b0000,32'h0000_B200,  0,8'hBC,2'd3,4'b0000,4'b0000);
        tbl[14] = v(0,1,4'b0010,4'b0000,32'h0000_B300,  0,8'hBC,2'd3,4'b0010,4'b0000);
        tbl[15] = v(0,1,4'b0010,4'b0010,32'h0000_B400,  0,8'hBC,2'd3,4'b0010,4'b0010);
        tbl[16] = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0010,4'b0010);
        tbl[17] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hB0,2'd1,4'b0000,4'b0010);
        tbl[18] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hB1,2'd1,4'b0000,4'b0010);
        tbl[19] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hB2,2'd1,4'b0000,4'b0010);
        tbl[20] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hB3,2'd1,4'b0000,4'b0010);
        tbl[21] = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd1,4'b0000,4'b0010);
        tbl[22] = v(0,0,4'b1001,4'b0000,32'hD000_00C0,  0,8'hBC,2'd1,4'b0000,4'b0010);
        tbl[23] = v(0,0,4'b1001,4'b0000,32'hD100_00C1,  1,8'hD0,2'd3,4'b0000,4'b0010);
        tbl[24] = v(0,1,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0000,4'b0010);
        tbl[25] = v(0,1,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0000,4'b0010);
        tbl[26] = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd3,4'b0000,4'b0010);
        tbl[27] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hC0,2'd0,4'b0000,4'b0010);
        tbl[28] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hD1,2'd3,4'b0000,4'b0010);
        tbl[29] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hC1,2'd0,4'b0000,4'b0010);
        tbl[30] = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd0,4'b0000,4'b0010);
        tbl[31] = v(0,0,4'b0100,4'b0000,32'h00E0_0000,  0,8'hBC,2'd0,4'b0000,4'b0010);
        tbl[32] = v(0,0,4'b0100,4'b0000,32'h00E1_0000,  1,8'hE0,2'd2,4'b0000,4'b0010);
        tbl[33] = v(0,0,4'b0101,4'b0000,32'h00E2_00F0,  1,8'hE1,2'd2,4'b0000,4'b0010);
        tbl[34] = v(0,0,4'b0100,4'b0000,32'h00E3_0000,  1,8'hF0,2'd0,4'b0000,4'b0010);
        tbl[35] = v(0,0,4'b0100,4'b0000,32'h00E4_0000,  1,8'hE2,2'd2,4'b0000,4'b0010);
        tbl[36] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hE3,2'd2,4'b0000,4'b0010);
        tbl[37] = v(0,0,4'b0000,4'b0000,32'h0,          1,8'hE4,2'd2,4'b0000,4'b0010);
        tbl[38] = v(0,0,4'b0000,4'b0000,32'h0,          0,8'hBC,2'd2,4'b0000,4'b0010);

        reset = 1'b1;
        recirculacion = 1'b1;
        drive(4'b0000, 32'h0, 4'b0000);
        tick();
        tick();
        chk("rst_data_out",  {24'h0, data_out}, 32'hBC);
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_grant",     {30'h0, grant_lane}, 32'h0);
        chk("rst_full",      {28'h0, full3, full2, full1, full0}, 32'h0);
        chk("rst_ovf",       {28'h0, ovf}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst;
            recirculacion = tbl[i].rc;
            if (tbl[i].rst) flush_sb();
            drive(tbl[i].vld, tbl[i].din, tbl[i].drop);
            tick();
            chk($sformatf("row%0d_valid", i), {31'h0, valid_out}, {31'h0, tbl[i].ev});
            chk($sformatf("row%0d_data", i),  {24'h0, data_out}, {24'h0, tbl[i].ed});
            chk($sformatf("row%0d_grant", i), {30'h0, grant_lane}, {30'h0, tbl[i].eg});
            chk($sformatf("row%0d_full", i),  {28'h0, full3, full2, full1, full0}, {28'h0, tbl[i].ef});
            chk($sformatf("row%0d_ovf", i),   {28'h0, ovf}, {28'h0, tbl[i].eo});
        end

        // Reset in the middle of a stream: one byte out, three still buffered.
        drive(4'b1111, 32'hC3C2_C1C0, 4'b0000);
        tick();
        drive(4'b0000, 32'h0, 4'b0000);
        tick();
        chk("mid_valid_before_rst", {31'h0, valid_out}, 32'h1);
        chk("mid_grant_before_rst", {30'h0, grant_lane}, 32'h3);
        reset = 1'b1;
        #1;
        chk("async_rst_data",  {24'h0, data_out}, 32'hBC);
        chk("async_rst_valid", {31'h0, valid_out}, 32'h0);
        chk("async_rst_ovf",   {28'h0, ovf}, 32'h0);
        chk("async_rst_full",  {28'h0, full3, full2, full1, full0}, 32'h0);
        flush_sb();
        tick();
        tick();
        reset = 1'b0;
        recirculacion = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_idle%0d", c), {31'h0, valid_out}, 32'h0);
        end
        drive(4'b1001, 32'h5300_0050, 4'b0000);
        tick();
        drive(4'b0000, 32'h0, 4'b0000);
        tick();
        chk("first_grant_lane", {30'h0, grant_lane}, 32'h0);
        chk("first_grant_data", {24'h0, data_out}, 32'h50);
        tick();
        chk("second_grant_lane", {30'h0, grant_lane}, 32'h3);
        chk("second_grant_data", {24'h0, data_out}, 32'h53);
        tick();
        chk("drain_idle", {31'h0, valid_out}, 32'h0);

        chk("sb_pending_bytes", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
